// File: rtl/serial_echo_tx_pkg.sv
// serial_echo_tx_pkg: shared ASCII/frame constants, tx state encoding and digit mapping
package serial_echo_tx_pkg;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_BAD = 8'h3F;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int FRAME_BITS = 10;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic logic [7:0] digit_ascii(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9 ? ASCII_ZERO + {4'b0, d} : ASCII_BAD;
  endfunction
endpackage

// File: rtl/serial_echo_tx_uart_tx_byte.sv
// uart_tx_byte: 8N1 framer that chains the next character straight out of the stop bit
module uart_tx_byte
  import serial_echo_tx_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       IN_clk,
  input  logic       IN_rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ser,
  output logic       ready,
  output logic       busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  tx_state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0] idx, idx_d;
  logic [7:0] shreg;
  logic last, ser_d;
  assign last = cnt == CW'(OVERSAMPLE - 1);
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      ser <= 1'b1;
    end else begin
      state <= state_d;
      cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      idx <= idx_d;
      shreg <= (start && ready) ? data : shreg;
      ser <= ser_d;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = start ? START : IDLE;
      START: state_d = last ? DATA : START;
      DATA: state_d = (last && idx == 3'd7) ? STOP : DATA;
      STOP: state_d = !last ? STOP : start ? START : IDLE;
      default: state_d = IDLE;
    endcase
    idx_d = (state == DATA && last) ? idx + 3'd1 : idx;
  end
  always_comb begin
    ready = state == IDLE || (state == STOP && last);
    busy = state != IDLE;
    ser_d = state_d == START ? 1'b0 : state_d == DATA ? shreg[idx_d] : 1'b1;
  end
endmodule

// File: rtl/serial_echo_tx.sv
// serial_echo_tx: latch received digits and echo them as ASCII (plus optional CR/LF) over 8N1
module serial_echo_tx
  import serial_echo_tx_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int MAX_DIGITS = 16,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                          IN_clk,
  input  logic                          IN_rst,
  input  logic [MAX_DIGITS*DIGIT_W-1:0] IN_data,
  input  logic [4:0]                    IN_number,
  input  logic                          IN_shake_hand,
  output logic                          OUT_ser,
  output logic                          OUT_busy,
  output logic                          OUT_done,
  output logic                          OUT_dropped
);
  localparam int DW = MAX_DIGITS * DIGIT_W;
  localparam int CW = $clog2(MAX_DIGITS + 3);
  logic shake_q, rise, load, start, dphase, tx_ready, tx_busy, done_d;
  logic [CW-1:0] n_in, cnt_in, left_q, dl_q, cur_left, cur_dl;
  logic [DW-1:0] sh_in, sh_q, cur_sh;
  logic [7:0] tx_byte;
  always_comb begin
    rise = IN_shake_hand && !shake_q;
    load = rise && !tx_busy;
    n_in = int'(IN_number) > MAX_DIGITS ? CW'(MAX_DIGITS) : CW'(IN_number);
    cnt_in = n_in + (APPEND_CRLF ? CW'(2) : CW'(0));
    sh_in = IN_data << (DIGIT_W * (MAX_DIGITS - int'(n_in)));
    cur_sh = load ? sh_in : sh_q;
    cur_left = load ? cnt_in : left_q;
    cur_dl = load ? n_in : dl_q;
    dphase = cur_dl != '0;
    tx_byte = dphase ? digit_ascii(cur_sh[DW-1 -: DIGIT_W]) : cur_left == CW'(2) ? ASCII_CR : ASCII_LF;
    start = tx_ready && cur_left != '0;
    done_d = (load && cnt_in == '0) || (tx_ready && tx_busy && left_q == '0);
  end
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      shake_q <= 1'b0;
      sh_q <= '0;
      left_q <= '0;
      dl_q <= '0;
      OUT_done <= 1'b0;
      OUT_dropped <= 1'b0;
    end else begin
      shake_q <= IN_shake_hand;
      OUT_done <= done_d;
      OUT_dropped <= rise && tx_busy;
      if (start) begin
        left_q <= cur_left - 1'b1;
        dl_q <= dphase ? cur_dl - 1'b1 : cur_dl;
        sh_q <= dphase ? cur_sh << DIGIT_W : cur_sh;
      end
    end
  end
  uart_tx_byte #(.OVERSAMPLE(OVERSAMPLE)) u_tx (
    .IN_clk(IN_clk),
    .IN_rst(IN_rst),
    .start(start),
    .data(tx_byte),
    .ser(OUT_ser),
    .ready(tx_ready),
    .busy(tx_busy)
  );
  assign OUT_busy = tx_busy;
endmodule

// File: tb/tb_serial_echo_tx.sv
// tb_serial_echo_tx: waveform-model checker for the CRLF and no-CRLF echo transmitters
module tb_serial_echo_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, shake = 1'b0;
  logic [63:0] data = '0;
  logic [4:0] number = '0;
  logic [1:0] ser, busy, done, dropped;
  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  logic prev = 1'b0;
  logic act [2];
  int s [2], nch [2], dn_a [2], dn_b [2], drp [2];
  logic [7:0] mc [2][18];
  int rx_cnt [2] = '{-1, -1};
  int rx_n [2] = '{0, 0};
  int last_done [2] = '{-1, -1};
  int last_drop [2] = '{-1, -1};
  logic [7:0] rx_sh [2];
  logic [7:0] rx_buf [2][512];
  string p_name;
  logic [143:0] p_got, p_exp;
  int p_seq = 0, p_seen = 0;

  serial_echo_tx #(.APPEND_CRLF(1'b1)) dut (
    .IN_clk(clk), .IN_rst(rst), .IN_data(data), .IN_number(number), .IN_shake_hand(shake),
    .OUT_ser(ser[0]), .OUT_busy(busy[0]), .OUT_done(done[0]), .OUT_dropped(dropped[0])
  );
  serial_echo_tx #(.APPEND_CRLF(1'b0)) dut_nc (
    .IN_clk(clk), .IN_rst(rst), .IN_data(data), .IN_number(number), .IN_shake_hand(shake),
    .OUT_ser(ser[1]), .OUT_busy(busy[1]), .OUT_done(done[1]), .OUT_dropped(dropped[1])
  );

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return d < 4'd10 ? 8'h30 + {4'b0, d} : 8'h3F;
  endfunction

  always @(posedge clk) begin
    logic rise;
    int n;
    if (rst) begin
      prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        act[i] = 1'b0;
        dn_a[i] = -1;
        dn_b[i] = -1;
        drp[i] = -1;
      end
    end else begin
      rise = shake && !prev;
      prev = shake;
      for (int i = 0; i < 2; i++) if (rise) begin
        if (act[i] && cyc < s[i] + nch[i] * 160) drp[i] = cyc + 1;
        else begin
          n = int'(number) > 16 ? 16 : int'(number);
          nch[i] = n + (i == 0 ? 2 : 0);
          for (int k = 0; k < n; k++) mc[i][k] = ascii(data[4*(n-1-k) +: 4]);
          if (i == 0) begin
            mc[i][n] = 8'h0D;
            mc[i][n+1] = 8'h0A;
          end
          s[i] = cyc + 1;
          act[i] = 1'b1;
          dn_b[i] = dn_a[i];
          dn_a[i] = cyc + 1 + nch[i] * 160;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    int k, b;
    logic eb, es, ed, ep;
    if (cyc >= 1) for (int i = 0; i < 2; i++) begin
      k = cyc - s[i];
      b = (k % 160) / 16;
      eb = act[i] && k >= 0 && k < nch[i] * 160;
      es = !eb ? 1'b1 : b == 0 ? 1'b0 : b == 9 ? 1'b1 : mc[i][k/160][b-1];
      ed = cyc == dn_a[i] || cyc == dn_b[i];
      ep = cyc == drp[i];
      tests++;
      if ({ser[i], busy[i], done[i], dropped[i]} !== {es, eb, ed, ep}) begin
        fails++;
        $display("FAIL wave cycle %0d inst %0d ser/busy/done/dropped got %b%b%b%b expected %b%b%b%b",
                 cyc, i, ser[i], busy[i], done[i], dropped[i], es, eb, ed, ep);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) rx_cnt[i] = -1;
      else if (rx_cnt[i] < 0) begin
        if (ser[i] === 1'b0) rx_cnt[i] = 0;
      end else begin
        rx_cnt[i]++;
        if (rx_cnt[i] % 16 == 8 && rx_cnt[i] >= 24 && rx_cnt[i] <= 136) rx_sh[i][rx_cnt[i]/16 - 1] = ser[i];
        if (rx_cnt[i] == 152) begin
          if (rx_n[i] < 512) rx_buf[i][rx_n[i]] = rx_sh[i];
          rx_n[i]++;
          rx_cnt[i] = -1;
        end
      end
      if (done[i] === 1'b1) last_done[i] = cyc;
      if (dropped[i] === 1'b1) last_drop[i] = cyc;
    end
    if (p_seq != p_seen) begin
      p_seen = p_seq;
      tests++;
      if (p_got !== p_exp) begin
        fails++;
        $display("FAIL %s got %0h expected %0h", p_name, p_got, p_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [143:0] got, input logic [143:0] exp);
    tick();
    p_name = name;
    p_got = got;
    p_exp = exp;
    p_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] d, input logic [4:0] n, input int hold);
    tick();
    data = d;
    number = n;
    shake = 1'b1;
    t0 = cyc;
    repeat (hold) tick();
    shake = 1'b0;
    data = {$urandom, $urandom};
    number = 5'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy != 2'b00 && k < 4000);
    repeat (3) @(negedge clk);
    pin("idle", {142'b0, busy}, '0);
  endtask

  function automatic logic [143:0] pack(input int i, input int base);
    logic [143:0] r = '0;
    for (int k = base; k < rx_n[i] && k < 512; k++) r = {r[135:0], rx_buf[i][k]};
    return r;
  endfunction

  task automatic check(input string name, input int b0, input int b1, input logic [143:0] e0,
                       input logic [143:0] e1, input int d0, input int d1);
    pin({name, "_done_crlf"}, 144'(last_done[0] - t0), 144'(d0));
    pin({name, "_done_nocrlf"}, 144'(last_done[1] - t0), 144'(d1));
    pin({name, "_bytes_crlf"}, pack(0, b0), e0);
    pin({name, "_bytes_nocrlf"}, pack(1, b1), e1);
  endtask

  initial begin
    int b0, b1;
    logic [3:0] mid;
    repeat (3) tick();
    rst = 1'b0;
    pin("rst_ser", {142'b0, ser}, 144'h3);
    pin("rst_busy", {142'b0, busy}, '0);
    pin("rst_flags", {140'b0, done, dropped}, '0);
    b0 = rx_n[0]; b1 = rx_n[1];
    load(64'h123, 5'd3, 1);
    wait_idle();
    check("basic", b0, b1, {"123", 8'h0D, 8'h0A}, "123", 801, 481);
    b0 = rx_n[0]; b1 = rx_n[1];
    load(64'h7, 5'd1, 1);
    wait_idle();
    check("bit", b0, b1, {"7", 8'h0D, 8'h0A}, "7", 481, 161);
    b0 = rx_n[0]; b1 = rx_n[1];
    load(64'h0123456789ABCDEF, 5'd20, 1);
    wait_idle();
    check("clamp", b0, b1, {"0123456789??????", 8'h0D, 8'h0A}, "0123456789??????", 2881, 2561);
    b0 = rx_n[0]; b1 = rx_n[1];
    load(64'h5, 5'd0, 1);
    wait_idle();
    check("empty", b0, b1, {8'h0D, 8'h0A}, '0, 321, 1);
    b0 = rx_n[0]; b1 = rx_n[1];
    load(64'h123, 5'd3, 1);
    repeat (49) tick();
    shake = 1'b1;
    tick();
    shake = 1'b0;
    wait_idle();
    check("overlap", b0, b1, {"123", 8'h0D, 8'h0A}, "123", 801, 481);
    pin("overlap_drop_crlf", 144'(last_drop[0] - t0), 144'd51);
    pin("overlap_drop_nocrlf", 144'(last_drop[1] - t0), 144'd51);
    b0 = rx_n[0]; b1 = rx_n[1];
    load(64'h45, 5'd2, 100);
    wait_idle();
    check("held", b0, b1, {"45", 8'h0D, 8'h0A}, "45", 641, 321);
    load(64'h123, 5'd3, 1);
    repeat (39) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    mid = {ser, busy};
    pin("rst_mid_ser_busy", {140'b0, mid}, 144'hC);
    b0 = rx_n[0]; b1 = rx_n[1];
    load(64'h98, 5'd2, 1);
    wait_idle();
    check("after_rst", b0, b1, {"98", 8'h0D, 8'h0A}, "98", 641, 321);
    for (int it = 0; it < 10; it++) begin
      load({$urandom, $urandom}, 5'($urandom_range(0, 20)), $urandom_range(1, 3));
      for (int c = 0; c < 3000; c++) begin
        tick();
        data = {$urandom, $urandom};
        number = 5'($urandom);
        if ($urandom_range(0, 99) == 0) shake = ~shake;
        rst = (it % 3 == 2 && c == 200);
      end
      rst = 1'b0;
      shake = 1'b0;
      wait_idle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_echo_tx.md
Name: serial_echo_tx

Overview:
- Downstream consumer of the 16x-oversampled serial receiver.
- On the receiver's handshake pulse, it latches the packed 4-bit digit word and the digit count.
- It then transmits the digits back as ASCII characters on a serial line, followed by an optional CR/LF. Line format is 8N1 at 9600 baud, using the same 9600*16 Hz clock.
- It lets the host confirm what was received and closes the loop for board bring-up.

Parameters:
- OVERSAMPLE, 16, clock cycles per serial bit.
- MAX_DIGITS, 16, nibble slots in IN_data (64/4).
- APPEND_CRLF, 1, when 1 append 0x0D then 0x0A after the digits.

Ports:
- IN_clk  input  1  9600*16 Hz clock. Single clock domain.
- IN_rst  input  1  Reset. Synchronous, active-high.
- IN_data  input  64  Packed digits. Newest digit is in [3:0]; older digits are in successively higher nibbles.
- IN_number  input  5  Count of digits received. May exceed 16.
- IN_shake_hand  input  1  Load strobe. Only the rising edge is used, detected internally against a registered copy.
- OUT_ser  output  1  Serial TX line. Idles high.
- OUT_busy  output  1  High whenever the block is not in IDLE.
- OUT_done  output  1  One-cycle pulse at the end of the last stop bit.
- OUT_dropped  output  1  One-cycle pulse when a load strobe rises while busy.

Behaviour:
- Reset values: OUT_ser=1, OUT_busy=0, OUT_done=0, OUT_dropped=0. State=IDLE; all counters are zero.
- Reset mid-frame aborts immediately. OUT_ser is 1 on the cycle after IN_rst is sampled high. No partial character is completed.
- Load (cycle T: IN_shake_hand rising edge while in IDLE):
  - n = min(IN_number, 16).
  - Shift register = IN_data << 4*(16-n), so the oldest valid digit sits in [63:60].
  - Character count = n + (APPEND_CRLF ? 2 : 0).
- Character count of 0 (n=0 and APPEND_CRLF=0): pulse OUT_done at T+1, stay in IDLE, and never drive OUT_busy.
- Otherwise the block enters START at T+1. OUT_ser=0 and OUT_busy=1 from T+1.
- States:
  - IDLE -> START on load.
  - START (1 bit) -> DATA.
  - DATA (8 bits, LSB first) -> STOP.
  - STOP (1 bit, OUT_ser=1) -> START if characters remain, else IDLE.
- Each bit lasts exactly OVERSAMPLE cycles, counted by a bit-cycle counter from 0 to OVERSAMPLE-1.
- There is no idle gap between characters. A frame is 10*OVERSAMPLE cycles.
- Character byte, selected at START entry:
  - Digit phase: top nibble d. Byte = 0x30+d for d<=9, else 0x3F ('?'). The shift register then moves left by 4.
  - CRLF phase: 0x0D, then 0x0A.
- Completion: OUT_done pulses on the first cycle after the final stop bit. That cycle is T+1+chars*10*OVERSAMPLE. OUT_busy is 0 on that same cycle.
- A load strobe rising edge while busy: pulse OUT_dropped the next cycle. The frame in flight and the latched data are unaffected.
- A strobe held high produces exactly one load or one drop.
- Latched data is immune to IN_data and IN_number changes after load.
- OUT_ser is registered and glitch-free.

Decomposition:
- Shared package:
  - Constants ASCII_ZERO=8'h30, ASCII_BAD=8'h3F, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - Frame constants: FRAME_BITS=10, DIGIT_W=4.
  - State encoding: IDLE, START, DATA, STOP.
- One sub-module: uart_tx_byte.
  - Inputs: start, byte. Outputs: ser, ready.
  - Handles the 8N1 framing and bit timing.
- serial_echo_tx owns latching, the digit shifter, ASCII mapping, CRLF sequencing and the flags.

Test Plan:
- Basic digits: IN_number=3, IN_data=64'h123. Required bytes on OUT_ser: 0x31, 0x32, 0x33, 0x0D, 0x0A. OUT_done at T+801. OUT_busy high on T+1..T+800.
- Bit timing: single-digit load 64'h7 with APPEND_CRLF=0.
  - Start bit low for exactly 16 cycles from T+1.
  - Data bits 0x37 sampled LSB-first at cycle 8 of each bit.
  - Stop high. OUT_done at T+161.
- Clamp and mapping: IN_number=20, IN_data=64'h0123456789ABCDEF. Required: 16 chars "0123456789??????", then CR LF. OUT_done at T+2881.
- Empty: IN_number=0 sends only 0x0D, 0x0A with OUT_done at T+321. With APPEND_CRLF=0: OUT_done at T+1, OUT_busy never high, OUT_ser stays 1.
- Overlap: a second strobe rising at T+50. Required: OUT_dropped pulses at T+51 and the first transmission is bit-identical to the no-overlap case. A strobe held high for 100 cycles gives exactly one load.
- Reset mid-frame: assert IN_rst at T+40 for 1 cycle. Required: OUT_ser=1, OUT_busy=0 at T+41. A fresh load afterwards transmits correctly from its first character.
